// File: rtl/hdmi_link_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_link_ctrl
//
// Brings up an HDMI transmit link. It waits for a stable clock-generator lock,
// holds the serializer in reset for a fixed time, writes five video-timing
// words to the transmitter core over a valid/ready handshake, and then enables
// pixel streaming. Lock loss or a restart request sends it back to the start.
//
// Optional feature (macro HDMI_LINK_CTRL_TIMEOUT_EN):
//   When defined, a stalled config handshake that lasts CFG_TIMEOUT cycles
//   moves the controller to FAULT and sets the sticky o_err flag. When the
//   macro is undefined, CFG waits indefinitely and o_err is constant 0.
//
// Parameters:
//   LOCK_STABLE  consecutive i_locked-high cycles needed to qualify lock
//   RST_CYCLES   cycles o_serdes_rst is held once lock qualifies
//   H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL  video timing values written in CFG
//   CFG_TIMEOUT  maximum handshake stall (timeout build only)
//
// Ports:
//   clk           in   pixel clock, the only clock
//   rstn          in   asynchronous active-low reset
//   i_locked      in   clock-generator locked status (synchronous to clk)
//   i_restart     in   single-cycle restart request
//   i_cfg_ready   in   transmitter core accepts the current config word
//   o_cfg_valid   out  config word valid
//   o_cfg_data    out  config word: [31:24] address, [23:0] value
//   o_serdes_rst  out  serializer reset, active-high
//   o_rgb_en      out  pixel data enable into the transmitter core
//   o_link_up     out  link configured and streaming
//   o_err         out  sticky configuration-timeout flag
// -----------------------------------------------------------------------------
module hdmi_link_ctrl #(
  parameter int LOCK_STABLE = 16,
  parameter int RST_CYCLES  = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int CFG_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_locked,
  input  logic        i_restart,
  input  logic        i_cfg_ready,
  output logic        o_cfg_valid,
  output logic [31:0] o_cfg_data,
  output logic        o_serdes_rst,
  output logic        o_rgb_en,
  output logic        o_link_up,
  output logic        o_err
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SERDES_RST,
    CFG,
    STREAM,
    FAULT
  } state_t;

  localparam int LCW = $clog2(LOCK_STABLE + 1);
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [2:0] LAST_WORD = 3'd4;

  state_t           state;
  logic [LCW-1:0]   lock_cnt;
  logic [RCW-1:0]   rst_cnt;
  logic [2:0]       word_idx;
  logic             lock_lost;
  logic             restart_req;
  logic             abort;

`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(CFG_TIMEOUT + 1);
  logic [TCW-1:0]   to_cnt;
  logic             err_q;
`endif

  // Config word table; timing values are zero-extended into the 24-bit field.
  function automatic logic [31:0] cfg_word(input logic [2:0] idx);
    case (idx)
      3'd0:    cfg_word = {8'h00, 24'(H_ACTIVE)};
      3'd1:    cfg_word = {8'h01, 24'(H_TOTAL)};
      3'd2:    cfg_word = {8'h02, 24'(V_ACTIVE)};
      3'd3:    cfg_word = {8'h03, 24'(V_TOTAL)};
      default: cfg_word = {8'h04, 24'h1};
    endcase
  endfunction

  // Lock loss is honoured everywhere except WAIT_LOCK (already there) and
  // FAULT (which only restart or reset may leave). Restart is ignored until
  // the link has started configuring. Both lead to the same WAIT_LOCK entry.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lock_lost   = 1'b0;
    restart_req = 1'b0;
    if (!i_locked && (state == SERDES_RST || state == CFG || state == STREAM))
      lock_lost = 1'b1;
    if (i_restart && (state == CFG || state == STREAM || state == FAULT))
      restart_req = 1'b1;
    abort = lock_lost || restart_req;
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= WAIT_LOCK;
      lock_cnt     <= '0;
      rst_cnt      <= '0;
      word_idx     <= '0;
      o_cfg_valid  <= 1'b0;
      o_cfg_data   <= '0;
      o_serdes_rst <= 1'b1;
      o_rgb_en     <= 1'b0;
      o_link_up    <= 1'b0;
`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else if (abort) begin
      // Abandon any pending word and restart sequencing from scratch.
      state        <= WAIT_LOCK;
      lock_cnt     <= '0;
      rst_cnt      <= '0;
      word_idx     <= '0;
      o_cfg_valid  <= 1'b0;
      o_cfg_data   <= '0;
      o_serdes_rst <= 1'b1;
      o_rgb_en     <= 1'b0;
      o_link_up    <= 1'b0;
`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!i_locked) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LCW'(LOCK_STABLE - 1)) begin
            // This edge brings the count to LOCK_STABLE: lock qualifies.
            lock_cnt <= '0;
            rst_cnt  <= '0;
            state    <= SERDES_RST;
          end else begin
            lock_cnt <= lock_cnt + LCW'(1);
          end
        end

        SERDES_RST: begin
          if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
            rst_cnt      <= '0;
            word_idx     <= '0;
            o_serdes_rst <= 1'b0;
            state        <= CFG;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end

        CFG: begin
          if (!o_cfg_valid) begin
            // First CFG cycle: present word 0.
            o_cfg_valid <= 1'b1;
            o_cfg_data  <= cfg_word(3'd0);
          end else if (i_cfg_ready) begin
`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
            to_cnt <= '0;
`endif
            if (word_idx == LAST_WORD) begin
              o_cfg_valid <= 1'b0;
              o_cfg_data  <= '0;
              word_idx    <= '0;
              o_rgb_en    <= 1'b1;
              o_link_up   <= 1'b1;
              state       <= STREAM;
            end else begin
              // Next word follows back-to-back; valid stays high.
              word_idx   <= word_idx + 3'd1;
              o_cfg_data <= cfg_word(word_idx + 3'd1);
            end
          end
`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
          else if (to_cnt == TCW'(CFG_TIMEOUT - 1)) begin
            // CFG_TIMEOUT consecutive stalled cycles: give up.
            to_cnt       <= '0;
            o_cfg_valid  <= 1'b0;
            o_cfg_data   <= '0;
            word_idx     <= '0;
            o_serdes_rst <= 1'b1;
            err_q        <= 1'b1;
            state        <= FAULT;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
`endif
        end

        STREAM: begin
          // Held until lock loss or restart, both handled by the abort path.
        end

        FAULT: begin
          // Left only through restart (abort path) or reset.
        end

        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

`ifdef HDMI_LINK_CTRL_TIMEOUT_EN
  assign o_err = err_q;
`else
  // Without the timeout feature FAULT is unreachable and the flag is tied off.
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^CFG_TIMEOUT;
  assign o_err = 1'b0;
`endif

endmodule
